// File: rtl/flappy_pkg.sv
// Shared Flappy Bird datapath definitions: round states, screen and bird geometry,
// physics constants and the bird bounding-box payload handed to the pipe stage.
package flappy_pkg;

  typedef enum logic [1:0] {
    READY   = 2'd0,
    FLYING  = 2'd1,
    FALLING = 2'd2,
    DEAD    = 2'd3
  } state_t;

  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned TICK_DIV     = 1_000_000;
  localparam int unsigned GRAVITY      = 1;
  localparam int unsigned FLAP_IMPULSE = 8;
  localparam int unsigned MAX_FALL     = 10;
  localparam int unsigned BIRD_X       = 160;
  localparam int unsigned BIRD_W       = 20;
  localparam int unsigned BIRD_H       = 16;
  localparam int unsigned START_Y      = 232;
  localparam int unsigned CEIL_Y       = 0;
  localparam int unsigned GROUND_Y     = SCREEN_H;

  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned SIZE_W = 5;
  localparam int unsigned VEL_W  = 6;
  localparam int unsigned POS_W  = 11;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [SIZE_W-1:0] w;
    logic [SIZE_W-1:0] h;
  } bird_box_t;

  // Gravity-accelerated velocity, saturated at terminal fall speed.
  function automatic logic signed [VEL_W-1:0] fall_vel(input logic signed [VEL_W-1:0] vel);
    logic signed [VEL_W:0] v_sum;
    logic signed [VEL_W:0] v_max;
    v_sum = (VEL_W+1)'(vel) + $signed((VEL_W+1)'(GRAVITY));
    v_max = (VEL_W+1)'(MAX_FALL);
    return (v_sum > v_max) ? VEL_W'(v_max) : VEL_W'(v_sum);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button plus a registered one-cycle
// rising-edge pulse (three clocks from pin to pulse).
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
      o_rise <= r_sync & ~r_prev;
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion and round state machine for the Flappy Bird datapath.
// Define BIRD_INVULN_EN to make the bird ignore pipes and survive the ground.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int unsigned TICK_DIV_P = flappy_pkg::TICK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flap_btn,
  input  logic       pipe_collision,
  output logic [9:0] bird_x,
  output logic [9:0] bird_y,
  output logic [4:0] bird_w,
  output logic [4:0] bird_h,
  output logic       pipe_enable,
  output logic       alive,
  output logic       game_over,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W = (TICK_DIV_P > 1) ? $clog2(TICK_DIV_P) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV_P - 1);
  localparam logic signed [POS_W-1:0] Y_CEIL   = POS_W'(CEIL_Y);
  localparam logic signed [POS_W-1:0] Y_FLOOR  = POS_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0] H_BIRD   = POS_W'(BIRD_H);
  localparam logic signed [VEL_W-1:0] V_FLAP   = VEL_W'(FLAP_IMPULSE);
  localparam logic [Y_W-1:0]          Y_START  = Y_W'(START_Y);
  localparam logic [Y_W-1:0]          Y_TOP    = Y_W'(CEIL_Y);
  localparam logic [Y_W-1:0]          Y_REST   = Y_W'(GROUND_Y - BIRD_H);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [Y_W-1:0]            r_y;
  logic signed [VEL_W-1:0]   r_vel;
  logic                      r_flap_pending;

  logic                      w_flap_edge;
  logic                      w_tick;
  logic                      w_collide;
  logic                      w_fly_dies;
  logic                      w_do_flap;
  logic signed [VEL_W-1:0]   w_vel_step;
  logic signed [POS_W-1:0]   w_y_new;
  logic                      w_hit_ceil;
  logic                      w_hit_floor;
  logic [Y_W-1:0]            w_y_step;
  logic signed [VEL_W-1:0]   w_vel_next;
  bird_box_t                 w_box;

  btn_edge_sync u_flap_sync (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (flap_btn),
    .o_rise (w_flap_edge)
  );

  // Free-running physics step divider, shared timing with the pipe stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_tick = (r_cnt == CNT_LAST);

`ifdef BIRD_INVULN_EN
  logic w_collision_unused;
  assign w_collision_unused = pipe_collision;
  assign w_collide          = 1'b0;
  assign w_fly_dies         = 1'b0;
`else
  assign w_collide  = pipe_collision && (r_state == FLYING);
  assign w_fly_dies = w_tick && w_hit_floor;
`endif

  // A collision cancels any flap that would have been consumed on the same tick.
  assign w_do_flap = (r_state == FLYING) && (r_flap_pending || w_flap_edge) && !w_collide;

  // One physics step: flap or gravity, then clamp against ceiling and ground.
  always_comb begin
    w_vel_step  = w_do_flap ? -V_FLAP : fall_vel(r_vel);
    w_y_new     = $signed({1'b0, r_y}) + POS_W'(w_vel_step);
    w_hit_ceil  = (w_y_new < Y_CEIL);
    w_hit_floor = ((w_y_new + H_BIRD) >= Y_FLOOR);
    w_y_step    = Y_W'(w_y_new);
    w_vel_next  = w_vel_step;
    if (w_hit_ceil) begin
      w_y_step   = Y_TOP;
      w_vel_next = '0;
    end else if (w_hit_floor) begin
      w_y_step   = Y_REST;
      w_vel_next = '0;
    end
  end

  // Round FSM; status outputs are registered alongside each state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= READY;
      r_y            <= Y_START;
      r_vel          <= '0;
      r_flap_pending <= 1'b0;
      pipe_enable    <= 1'b0;
      alive          <= 1'b1;
      game_over      <= 1'b0;
    end else begin
      case (r_state)
        READY: begin
          r_y   <= Y_START;
          r_vel <= '0;
          if (w_flap_edge) begin
            r_state        <= FLYING;
            r_flap_pending <= 1'b1;
            pipe_enable    <= 1'b1;
          end
        end
        FLYING: begin
          if (w_tick) begin
            r_y   <= w_y_step;
            r_vel <= w_vel_next;
          end
          if (w_tick || w_collide) begin
            r_flap_pending <= 1'b0;
          end else if (w_flap_edge) begin
            r_flap_pending <= 1'b1;
          end
          if (w_fly_dies) begin
            r_state     <= DEAD;
            pipe_enable <= 1'b0;
            alive       <= 1'b0;
            game_over   <= 1'b1;
          end else if (w_collide) begin
            r_state     <= FALLING;
            pipe_enable <= 1'b0;
          end
        end
        FALLING: begin
          if (w_tick) begin
            r_y   <= w_y_step;
            r_vel <= w_vel_next;
            if (w_hit_floor) begin
              r_state   <= DEAD;
              alive     <= 1'b0;
              game_over <= 1'b1;
            end
          end
        end
        DEAD: begin
          if (w_flap_edge) begin
            r_state   <= READY;
            r_y       <= Y_START;
            r_vel     <= '0;
            alive     <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: begin
          r_state <= READY;
        end
      endcase
    end
  end

  assign w_box = '{x: X_W'(BIRD_X), y: r_y, w: SIZE_W'(BIRD_W), h: SIZE_W'(BIRD_H)};

  assign bird_x  = w_box.x;
  assign bird_y  = w_box.y;
  assign bird_w  = w_box.w;
  assign bird_h  = w_box.h;
  assign state_o = r_state;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics with a 4-cycle physics step; expected bird
// positions are hand-computed from the flap/gravity/clamp rules.
module tb_bird_physics;

  logic       clk = 1'b0;
  logic       reset;
  logic       flap_btn;
  logic       pipe_collision;
  logic [9:0] bird_x;
  logic [9:0] bird_y;
  logic [4:0] bird_w;
  logic [4:0] bird_h;
  logic       pipe_enable;
  logic       alive;
  logic       game_over;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  bird_physics #(.TICK_DIV_P(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .flap_btn       (flap_btn),
    .pipe_collision (pipe_collision),
    .bird_x         (bird_x),
    .bird_y         (bird_y),
    .bird_w         (bird_w),
    .bird_h         (bird_h),
    .pipe_enable    (pipe_enable),
    .alive          (alive),
    .game_over      (game_over),
    .state_o        (state_o)
  );

  // One clock: cyc counts posedges since reset release; ticks land on cyc % 4 == 0.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic press();
    flap_btn = 1'b1;
    step();
    step();
    flap_btn = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_round(input string tag, input logic [1:0] st, input logic pe,
                           input logic al, input logic go);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".pipe_en"}, 32'(pipe_enable), 32'(pe));
    chk({tag, ".alive"}, 32'(alive), 32'(al));
    chk({tag, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  initial begin
    int ey;
    reset          = 1'b1;
    flap_btn       = 1'b0;
    pipe_collision = 1'b0;
    @(negedge clk);
    chk_round("reset", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("reset.y", 32'(bird_y), 32'd232);
    chk("bird_x", 32'(bird_x), 32'd160);
    chk("bird_w", 32'(bird_w), 32'd20);
    chk("bird_h", 32'(bird_h), 32'd16);
    reset = 1'b0;
    cyc   = 0;

`ifdef BIRD_INVULN_EN
    press();
    run_to(4);   chk_round("inv.fly", 2'd1, 1'b1, 1'b1, 1'b0);
    run_to(8);   chk("inv.y8", 32'(bird_y), 32'd224);
    run_to(21);
    pipe_collision = 1'b1;
    step();
    pipe_collision = 1'b0;
    chk_round("inv.pipe", 2'd1, 1'b1, 1'b1, 1'b0);
    run_to(24);  chk("inv.y24", 32'(bird_y), 32'd202);
    run_to(168); chk("inv.ground_y", 32'(bird_y), 32'd464);
    chk_round("inv.ground", 2'd1, 1'b1, 1'b1, 1'b0);
    press();
    run_to(172); chk("inv.reflap_y", 32'(bird_y), 32'd456);
    chk_round("inv.reflap", 2'd1, 1'b1, 1'b1, 1'b0);
`else
    run_to(100);
    chk_round("idle", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("idle.y", 32'(bird_y), 32'd232);

    // First flap from READY, then the climb decays under gravity.
    press();
    run_to(104); chk_round("start", 2'd1, 1'b1, 1'b1, 1'b0);
    chk("start.y", 32'(bird_y), 32'd232);
    run_to(108); chk("climb1", 32'(bird_y), 32'd224);
    run_to(112); chk("climb2", 32'(bird_y), 32'd217);
    run_to(116); chk("climb3", 32'(bird_y), 32'd211);
    run_to(120); chk("climb4", 32'(bird_y), 32'd206);

    // Free fall saturates at 10 px/step and ends on the ground.
    run_to(184); chk("sat1", 32'(bird_y), 32'd261);
    run_to(188); chk("sat2", 32'(bird_y), 32'd271);
    run_to(264); chk("pre_ground", 32'(bird_y), 32'd461);
    chk_round("pre_ground", 2'd1, 1'b1, 1'b1, 1'b0);
    run_to(268); chk("ground.y", 32'(bird_y), 32'd464);
    chk_round("ground", 2'd3, 1'b0, 1'b0, 1'b1);
    press();
    run_to(271); chk("dead.frozen", 32'(bird_y), 32'd464);
    chk("dead.state", 32'(state_o), 32'd3);
    run_to(272); chk_round("restart", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("restart.y", 32'(bird_y), 32'd232);

    // Flap on every tick up into the ceiling.
    press();
    run_to(276); chk("fly2.state", 32'(state_o), 32'd1);
    for (int k = 0; k < 30; k++) begin
      press();
      step();
      step();
      ey = 232 - 8 * (k + 1);
      if (ey < 0) ey = 0;
      chk("ceiling", 32'(bird_y), 32'(ey));
    end
    run_to(400); chk("ceil.vel0", 32'(bird_y), 32'd1);
    run_to(404); chk("ceil.fall", 32'(bird_y), 32'd3);

    // Pipe hit mid-climb: FALLING keeps velocity and ignores flaps.
    run_to(448); chk("pre_hit.y", 32'(bird_y), 32'd85);
    press();
    run_to(452); chk("hit_climb1", 32'(bird_y), 32'd77);
    run_to(456); chk("hit_climb2", 32'(bird_y), 32'd70);
    run_to(457);
    pipe_collision = 1'b1;
    step();
    pipe_collision = 1'b0;
    chk_round("hit", 2'd2, 1'b0, 1'b1, 1'b0);
    chk("hit.y", 32'(bird_y), 32'd70);
    press();
    run_to(460); chk("fall.keepvel", 32'(bird_y), 32'd64);
    press();
    run_to(464); chk("fall.noflap1", 32'(bird_y), 32'd59);
    chk("fall.state", 32'(state_o), 32'd2);
    run_to(468); chk("fall.noflap2", 32'(bird_y), 32'd55);
    run_to(524); chk("fall.y524", 32'(bird_y), 32'd104);
    run_to(664); chk("fall.y664", 32'(bird_y), 32'd454);
    chk("fall.state664", 32'(state_o), 32'd2);
    run_to(668); chk("fall.ground", 32'(bird_y), 32'd464);
    chk_round("fall.dead", 2'd3, 1'b0, 1'b0, 1'b1);
    press();
    run_to(672); chk_round("ready2", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("ready2.y", 32'(bird_y), 32'd232);

    // Asynchronous reset mid-fall, away from any clock edge.
    press();
    run_to(676); chk("fly3.state", 32'(state_o), 32'd1);
    run_to(680); chk("fly3.y", 32'(bird_y), 32'd224);
    run_to(685);
    pipe_collision = 1'b1;
    step();
    pipe_collision = 1'b0;
    chk("fly3.hit", 32'(state_o), 32'd2);
    run_to(690);
    #2 reset = 1'b1;
    #1;
    chk_round("midreset", 2'd0, 1'b0, 1'b1, 1'b0);
    chk("midreset.y", 32'(bird_y), 32'd232);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Tick phase restarts from reset: first flap lands on cycle 8.
    press();
    run_to(4);   chk("post.state", 32'(state_o), 32'd1);
    run_to(7);   chk("post.y7", 32'(bird_y), 32'd232);
    run_to(8);   chk("post.y8", 32'(bird_y), 32'd224);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
